gmii_rx_monitor: RTL

GMII_RX_MONITOR -- requirements
Module: gmii_rx_monitor

---
 rtl/gmii_rx_monitor.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/gmii_rx_monitor.sv
// GMII receive monitor: tracks preamble/SFD framing, measures each frame, and
// offers a one-entry summary over a srdy/drdy handshake.
// Optional CRC-32 check of the FCS is compiled in with GMII_MON_CRC_EN.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line quiet, waiting for the first preamble byte
// PRE    | inside the preamble, waiting for the SFD (0xD5)
// DATA   | counting frame bytes after the SFD until dv falls
// DROP   | bad framing or post-reset; ignore bytes until dv falls
module gmii_rx_monitor #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gmii_tx_dv,
  input  logic [7:0]  gmii_txd,
  output logic        p_srdy,
  input  logic        p_drdy,
  output logic [15:0] p_len,
  output logic [7:0]  p_dest,
  output logic [7:0]  p_src,
  output logic [2:0]  p_err,
  output logic [15:0] frame_count,
  output logic [15:0] drop_count
);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

  localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_pre_cnt;
  logic [15:0] r_len;
  logic [7:0]  r_dest_cap;
  logic [7:0]  r_src_cap;
  logic        w_pre_start;
  logic        w_pre_more;
  logic        w_sfd;
  logic        w_frame_end;
  logic        w_bad_frame;
  logic        w_slot_free;
  logic        w_load;
  logic        w_busy_drop;
  logic        w_data_byte;
  logic        w_crc_bad;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_DROP;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pre_start = 1'b0;
    w_pre_more  = 1'b0;
    w_sfd       = 1'b0;
    w_frame_end = 1'b0;
    w_bad_frame = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (gmii_tx_dv) begin
          if (gmii_txd == 8'h55) begin
            w_state_nxt = S_PRE;
            w_pre_start = 1'b1;
          end else begin
            w_state_nxt = S_DROP;
            w_bad_frame = 1'b1;
          end
        end
      end
      S_PRE: begin
        // r_pre_cnt already counts the 0x55 bytes seen; an eighth one is a preamble error
        if (!gmii_tx_dv) begin
          w_state_nxt = S_IDLE;
          w_bad_frame = 1'b1;
        end else if (gmii_txd == 8'hD5) begin
          w_state_nxt = S_DATA;
          w_sfd       = 1'b1;
        end else if (gmii_txd == 8'h55 && r_pre_cnt != 3'd7) begin
          w_pre_more  = 1'b1;
        end else begin
          w_state_nxt = S_DROP;
          w_bad_frame = 1'b1;
        end
      end
      S_DATA: begin
        if (!gmii_tx_dv) begin
          w_state_nxt = S_IDLE;
          w_frame_end = 1'b1;
        end
      end
      S_DROP: begin
        if (!gmii_tx_dv) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_DROP;
    endcase
  end

  assign w_data_byte = (r_state == S_DATA) && gmii_tx_dv;
  assign w_slot_free = !p_srdy || p_drdy;
  assign w_load      = w_frame_end && w_slot_free;
  assign w_busy_drop = w_frame_end && !w_slot_free;

`ifdef GMII_MON_CRC_EN
  // Reflected-register form of the 0xC704DD7B good-frame residue
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  logic [31:0] r_crc;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (reset)            r_crc <= 32'h0;
    else if (w_sfd)       r_crc <= 32'hFFFFFFFF;
    else if (w_data_byte) r_crc <= crc32_byte(r_crc, gmii_txd);
  end

  assign w_crc_bad = (r_crc != CRC_RESIDUE);
`else
  assign w_crc_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre_cnt   <= 3'd0;
      r_len       <= 16'd0;
      r_dest_cap  <= 8'd0;
      r_src_cap   <= 8'd0;
      p_srdy      <= 1'b0;
      p_len       <= 16'd0;
      p_dest      <= 8'd0;
      p_src       <= 8'd0;
      p_err       <= 3'd0;
      frame_count <= 16'd0;
      drop_count  <= 16'd0;
    end else begin
      if (w_pre_start)     r_pre_cnt <= 3'd1;
      else if (w_pre_more) r_pre_cnt <= r_pre_cnt + 3'd1;

      // Capture registers are cleared at the SFD so short frames report zero
      if (w_sfd) begin
        r_len      <= 16'd0;
        r_dest_cap <= 8'd0;
        r_src_cap  <= 8'd0;
      end else if (w_data_byte) begin
        if (r_len != 16'hFFFF) r_len <= r_len + 16'd1;
        if (r_len == 16'd5)    r_dest_cap <= gmii_txd;
        if (r_len == 16'd11)   r_src_cap  <= gmii_txd;
      end

      if (w_load) begin
        p_srdy      <= 1'b1;
        p_len       <= r_len;
        p_dest      <= r_dest_cap;
        p_src       <= r_src_cap;
        p_err       <= {w_crc_bad, (r_len > MAX_LEN_W), (r_len < MIN_LEN_W)};
        frame_count <= frame_count + 16'd1;
      end else if (p_srdy && p_drdy) begin
        p_srdy      <= 1'b0;
      end

      if (w_bad_frame || w_busy_drop) drop_count <= drop_count + 16'd1;
    end
  end

endmodule
